// File: rtl/seven_seg_scan_ctrl.sv
// ============================================================================
// Module  : seven_seg_scan_ctrl
// Brief   : 4-digit seven-segment scan scheduler with per-slot blanking and
//           frame-boundary buffering of the displayed value.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module seven_seg_scan_ctrl #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_CYC   = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable_i,
    input  logic [15:0] disp_value_i,
    input  logic        disp_load_i,
    input  logic [3:0]  digit_mask_i,
    output logic [1:0]  s_o,
    output logic [3:0]  nibble_o,
    output logic        blank_o,
    output logic        frame_start_o,
    output logic        load_pending_o
);

    localparam int              CW        = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0]   CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0]   BLANK_END = CW'(BLANK_CYC - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BLANK = 2'd1;
    localparam logic [1:0] ST_SHOW  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    s_q, s_d;
    logic          commit_d;

    logic          blank_q, blank_d;
    logic          frame_start_q;
    logic          pending_q, pending_d;
    logic [15:0]   staged_q, staged_d;
    logic [15:0]   shadow_q, shadow_d;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            s_q     <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
        end
    end

    // Next-state logic; disabling wins over any slot advance
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        s_d      = s_q;
        commit_d = 1'b0;
        if (!enable_i) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            s_d     = 2'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d  = ST_BLANK;
                    cnt_d    = '0;
                    s_d      = 2'd0;
                    commit_d = 1'b1;
                end
                ST_BLANK: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == BLANK_END) begin
                        state_d = ST_SHOW;
                    end
                end
                ST_SHOW: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d    = '0;
                        s_d      = s_q + 2'd1;
                        state_d  = ST_BLANK;
                        commit_d = (s_q == 2'd3);
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    s_d     = 2'd0;
                end
            endcase
        end
    end

    // Output / buffer logic, computed from the upcoming state so outputs align with cnt
    always_comb begin
        blank_d   = (state_d != ST_SHOW) || !digit_mask_i[s_d];
        pending_d = pending_q;
        staged_d  = staged_q;
        shadow_d  = shadow_q;
        if (commit_d) begin
            pending_d = 1'b0;
            if (disp_load_i) begin
                staged_d = disp_value_i;
                shadow_d = disp_value_i;
            end else if (pending_q) begin
                shadow_d = staged_q;
            end
        end else if (disp_load_i) begin
            staged_d  = disp_value_i;
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blank_q       <= 1'b1;
            frame_start_q <= 1'b0;
            pending_q     <= 1'b0;
            staged_q      <= '0;
            shadow_q      <= '0;
        end else begin
            blank_q       <= blank_d;
            frame_start_q <= commit_d;
            pending_q     <= pending_d;
            staged_q      <= staged_d;
            shadow_q      <= shadow_d;
        end
    end

    assign s_o            = s_q;
    assign nibble_o       = shadow_q[{s_q, 2'b00} +: 4];
    assign blank_o        = blank_q;
    assign frame_start_o  = frame_start_q;
    assign load_pending_o = pending_q;

endmodule

`default_nettype wire

// File: tb/tb_seven_seg_scan_ctrl.sv
// ============================================================================
// Module  : tb_seven_seg_scan_ctrl
// Brief   : Directed plus randomized bench against a time-based reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seven_seg_scan_ctrl;

    localparam int RD = 8;
    localparam int BC = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        ld = 1'b0;
    logic [15:0] val = 16'h0;
    logic [3:0]  mask = 4'hF;
    logic [1:0]  s;
    logic [3:0]  nib;
    logic        blank, fs, lp;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: position within a scan derived from elapsed cycles since enable
    bit          m_act;
    int          m_t;
    logic [15:0] m_stg, m_shd;
    bit          m_pend, m_fs, m_blank;
    logic [1:0]  m_s;

    seven_seg_scan_ctrl #(.REFRESH_DIV(RD), .BLANK_CYC(BC)) dut (
        .clk(clk), .rst_n(rst_n), .enable_i(en), .disp_value_i(val),
        .disp_load_i(ld), .digit_mask_i(mask), .s_o(s), .nibble_o(nib),
        .blank_o(blank), .frame_start_o(fs), .load_pending_o(lp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_act = 0; m_t = 0; m_stg = '0; m_shd = '0;
        m_pend = 0; m_fs = 0; m_s = 2'd0; m_blank = 1;
    endtask

    task automatic model_edge();
        bit commit;
        commit = 0;
        if (!en) begin
            m_act = 0; m_t = 0;
        end else if (!m_act) begin
            m_act = 1; m_t = 0; commit = 1;
        end else begin
            m_t++;
            if (m_t % (4 * RD) == 0) commit = 1;
        end
        if (commit) begin
            if (ld) begin
                m_stg = val; m_shd = val;
            end else if (m_pend) begin
                m_shd = m_stg;
            end
            m_pend = 0;
        end else if (ld) begin
            m_stg = val; m_pend = 1;
        end
        m_fs    = commit;
        m_s     = m_act ? 2'((m_t / RD) % 4) : 2'd0;
        m_blank = !m_act || ((m_t % RD) < BC) || !mask[m_s];
    endtask

    task automatic check_all();
        check("s", 32'(s), 32'(m_s));
        check("nibble", 32'(nib), 32'((m_shd >> (4 * m_s)) & 16'hF));
        check("blank", 32'(blank), 32'(m_blank));
        check("frame_start", 32'(fs), 32'(m_fs));
        check("load_pending", 32'(lp), 32'(m_pend));
    endtask

    // One clock: model advances at the edge, outputs checked 1 time unit later
    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        @(negedge clk);
        ld = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic seek(input int slot, input int pos);
        int i;
        i = 0;
        while (i < 200 && !(m_act && m_s == 2'(slot) && (m_t % RD) == pos)) begin
            cycle();
            i++;
        end
        check("seek_timeout", 32'(i < 200), 32'd1);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_blank", 32'(blank), 32'd1);
        check("rst_s", 32'(s), 32'd0);
        check("rst_nib", 32'(nib), 32'd0);
        @(negedge clk);

        // Load then enable: value shown in the first frame
        val = 16'h1234; ld = 1'b1;
        cycle();
        check("pend_idle", 32'(lp), 32'd1);
        en = 1'b1;
        cycle();
        check("first_fs", 32'(fs), 32'd1);
        check("first_nib", 32'(nib), 32'h4);
        run(2 * RD);
        check("s2_nib", 32'(nib), 32'h2);

        // Mid-frame load waits for wrap
        seek(1, 3);
        val = 16'hABCD; ld = 1'b1;
        cycle();
        seek(3, 4);
        check("hold_nib", 32'(nib), 32'h1);
        seek(0, 0);
        check("wrap_nib", 32'(nib), 32'hD);

        // Last load wins; load on the commit edge bypasses
        seek(1, 2);
        val = 16'h1111; ld = 1'b1; cycle();
        val = 16'h2222; ld = 1'b1; cycle();
        seek(3, RD - 1);
        val = 16'h5678; ld = 1'b1;
        cycle();
        check("bypass_nib", 32'(nib), 32'h8);
        check("bypass_lp", 32'(lp), 32'd0);

        // Masked digit stays dark for its slot
        mask = 4'b1011;
        run(4 * RD);
        mask = 4'hF;

        // Disable mid-show, then re-enable
        seek(2, 5);
        en = 1'b0;
        cycle();
        check("dis_s", 32'(s), 32'd0);
        check("dis_blank", 32'(blank), 32'd1);
        en = 1'b1;
        run(RD + 2);

        // Asynchronous reset between edges while a digit is lit
        seek(1, 4);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_blank", 32'(blank), 32'd1);
        check("arst_s", 32'(s), 32'd0);
        check("arst_lp", 32'(lp), 32'd0);
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run(5);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            en   = ($urandom_range(0, 99) < 97);
            ld   = ($urandom_range(0, 99) < 8);
            val  = 16'($urandom);
            if ($urandom_range(0, 99) < 3) mask = 4'($urandom);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
